// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - hazard/stall controller signal bundle
interface hazard_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       i_id_rs1;
  logic [4:0]       i_id_rs2;
  logic             i_id_uses_rs1;
  logic             i_id_uses_rs2;
  logic             i_ex_MemRead;
  logic [4:0]       i_ex_rd;
  logic             i_branch_taken;
  logic             i_dmem_req;
  logic             i_dmem_ready;
  logic             o_pc_write;
  logic             o_ifid_write;
  logic             o_ctrl_bubble;
  logic             o_ifid_flush;
  logic             o_idex_flush;
  logic             o_pipe_hold;
  logic             o_mem_err;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [1:0]       o_state;

  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2, i_ex_MemRead, i_ex_rd,
           i_branch_taken, i_dmem_req, i_dmem_ready,
    output o_pc_write, o_ifid_write, o_ctrl_bubble, o_ifid_flush, o_idex_flush,
           o_pipe_hold, o_mem_err, o_stall_cnt, o_state
  );

  modport master (
    output i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2, i_ex_MemRead, i_ex_rd,
           i_branch_taken, i_dmem_req, i_dmem_ready,
    input  o_pc_write, o_ifid_write, o_ctrl_bubble, o_ifid_flush, o_idex_flush,
           o_pipe_hold, o_mem_err, o_stall_cnt, o_state
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - pipeline stall/flush sequencer
module hazard_stall_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input logic                      clk,
  input logic                      rst,
  hazard_stall_controller_if.slave bus
);
  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  localparam logic [3:0]  FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [16:0] TIMEOUT      = 17'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [3:0]       flush_q, flush_d;
  logic [15:0]      wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        luh;
  logic [16:0] wait_inc;
  logic        pc_write, ifid_write, ctrl_bubble, ifid_flush, idex_flush, pipe_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      flush_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    wait_d      = wait_q;
    err_d       = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ctrl_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_hold   = 1'b0;
    wait_inc    = {1'b0, wait_q} + 17'd1;
    luh = bus.i_ex_MemRead && (bus.i_ex_rd != 5'd0) &&
          ((bus.i_id_uses_rs1 && (bus.i_id_rs1 == bus.i_ex_rd)) ||
           (bus.i_id_uses_rs2 && (bus.i_id_rs2 == bus.i_ex_rd)));

    case (state_q)
      S_RUN: begin
        if (bus.i_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          ctrl_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flush_d = FLUSH_RELOAD;
            state_d = S_FLUSH;
          end
        end else if (bus.i_dmem_req && !bus.i_dmem_ready) begin
          // Memory stall freezes the back end instead of injecting a bubble
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
          wait_d     = 16'd1;
          state_d    = S_MEM_WAIT;
        end else if (luh) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          ctrl_bubble = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (bus.i_dmem_ready) begin
          wait_d  = '0;
          state_d = S_RUN;
        end else begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
          wait_d     = wait_inc[15:0];
          if (wait_inc >= TIMEOUT) begin
            wait_d  = '0;
            err_d   = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        ctrl_bubble = 1'b1;
        if (bus.i_branch_taken) begin
          flush_d = FLUSH_RELOAD;
        end else if (flush_q <= 4'd1) begin
          flush_d = '0;
          state_d = S_RUN;
        end else begin
          flush_d = flush_q - 4'd1;
        end
      end
      default: state_d = S_RUN;
    endcase

    cnt_d = (!pc_write && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

    // Safe values while reset holds the pipeline
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ctrl_bubble = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      pipe_hold   = 1'b0;
    end
  end

  assign bus.o_pc_write    = pc_write;
  assign bus.o_ifid_write  = ifid_write;
  assign bus.o_ctrl_bubble = ctrl_bubble;
  assign bus.o_ifid_flush  = ifid_flush;
  assign bus.o_idex_flush  = idex_flush;
  assign bus.o_pipe_hold   = pipe_hold;
  assign bus.o_mem_err     = err_q;
  assign bus.o_stall_cnt   = cnt_q;
  assign bus.o_state       = state_q;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - randomized check of two controller configurations against a reference model
module tb_hazard_stall_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] rs1 = '0, rs2 = '0, exrd = '0;
  logic u1 = 0, u2 = 0, mr = 0, br = 0, req = 0, rdy = 0;

  hazard_stall_controller_if #(.CNT_W(16)) bus_a ();
  hazard_stall_controller_if #(.CNT_W(2))  bus_b ();

  assign bus_a.i_id_rs1 = rs1;       assign bus_b.i_id_rs1 = rs1;
  assign bus_a.i_id_rs2 = rs2;       assign bus_b.i_id_rs2 = rs2;
  assign bus_a.i_id_uses_rs1 = u1;   assign bus_b.i_id_uses_rs1 = u1;
  assign bus_a.i_id_uses_rs2 = u2;   assign bus_b.i_id_uses_rs2 = u2;
  assign bus_a.i_ex_MemRead = mr;    assign bus_b.i_ex_MemRead = mr;
  assign bus_a.i_ex_rd = exrd;       assign bus_b.i_ex_rd = exrd;
  assign bus_a.i_branch_taken = br;  assign bus_b.i_branch_taken = br;
  assign bus_a.i_dmem_req = req;     assign bus_b.i_dmem_req = req;
  assign bus_a.i_dmem_ready = rdy;   assign bus_b.i_dmem_ready = rdy;

  hazard_stall_controller #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(255), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave));
  hazard_stall_controller #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 = running, 1 = waiting on memory, 2 = flushing
  int P_FC[2]  = '{2, 1};
  int P_TO[2]  = '{255, 4};
  int P_MAX[2] = '{65535, 3};
  int m_phase[2], m_flush_left[2], m_waited[2], m_err[2], m_stalls[2];

  function automatic bit load_use();
    return mr && (exrd != 0) && ((u1 && rs1 == exrd) || (u2 && rs2 == exrd));
  endfunction

  task automatic model_reset(input int k);
    m_phase[k] = 0; m_flush_left[k] = 0; m_waited[k] = 0; m_err[k] = 0; m_stalls[k] = 0;
  endtask

  // Expected {pc_write, ifid_write, bubble, ifid_flush, idex_flush, hold}
  task automatic model_eval(input int k, output logic [5:0] o);
    localparam logic [5:0] RUN_OK = 6'b110000, FLUSHING = 6'b111110,
                           HOLD = 6'b000001, BUBBLE_STALL = 6'b001000;
    if (rst) o = BUBBLE_STALL;
    else if (m_phase[k] == 2) o = FLUSHING;
    else if (m_phase[k] == 1) o = rdy ? RUN_OK : HOLD;
    else if (br) o = FLUSHING;
    else if (req && !rdy) o = HOLD;
    else if (load_use()) o = BUBBLE_STALL;
    else o = RUN_OK;
  endtask

  task automatic model_edge(input int k, input logic [5:0] o);
    int err_next = 0;
    if (rst) begin
      model_reset(k);
      return;
    end
    case (m_phase[k])
      0: if (br) begin
           if (P_FC[k] > 1) begin m_phase[k] = 2; m_flush_left[k] = P_FC[k] - 1; end
         end else if (req && !rdy) begin
           m_phase[k] = 1; m_waited[k] = 1;
         end
      1: if (rdy) m_phase[k] = 0;
         else begin
           m_waited[k]++;
           if (m_waited[k] >= P_TO[k]) begin m_phase[k] = 0; err_next = 1; end
         end
      default: if (br) m_flush_left[k] = P_FC[k] - 1;
               else begin
                 m_flush_left[k]--;
                 if (m_flush_left[k] == 0) m_phase[k] = 0;
               end
    endcase
    m_err[k] = err_next;
    if (!o[5] && m_stalls[k] < P_MAX[k]) m_stalls[k]++;
  endtask

  task automatic check_inst(input int k, input logic [5:0] e);
    logic [5:0] comb;
    logic [1:0] st;
    logic err;
    logic [31:0] cnt;
    if (k == 0) begin
      comb = {bus_a.o_pc_write, bus_a.o_ifid_write, bus_a.o_ctrl_bubble,
              bus_a.o_ifid_flush, bus_a.o_idex_flush, bus_a.o_pipe_hold};
      st = bus_a.o_state; err = bus_a.o_mem_err; cnt = 32'(bus_a.o_stall_cnt);
    end else begin
      comb = {bus_b.o_pc_write, bus_b.o_ifid_write, bus_b.o_ctrl_bubble,
              bus_b.o_ifid_flush, bus_b.o_idex_flush, bus_b.o_pipe_hold};
      st = bus_b.o_state; err = bus_b.o_mem_err; cnt = 32'(bus_b.o_stall_cnt);
    end
    check_eq($sformatf("comb%0d", k), 32'(comb), 32'(e));
    check_eq($sformatf("state%0d", k), 32'(st), 32'(m_phase[k]));
    check_eq($sformatf("mem_err%0d", k), 32'(err), 32'(m_err[k]));
    check_eq($sformatf("stall_cnt%0d", k), cnt, 32'(m_stalls[k]));
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1
  task automatic run_cycle();
    logic [5:0] e0, e1;
    #1;
    model_eval(0, e0); check_inst(0, e0);
    model_eval(1, e1); check_inst(1, e1);
    @(posedge clk);
    model_edge(0, e0);
    model_edge(1, e1);
    #1;
  endtask

  task automatic mid_reset();
    logic [5:0] e0, e1;
    #2;
    rst = 1'b1;
    model_reset(0); model_reset(1);
    #1;
    model_eval(0, e0); check_inst(0, e0);
    model_eval(1, e1); check_inst(1, e1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_inputs();
    rs1 = 0; rs2 = 0; exrd = 0; u1 = 0; u2 = 0; mr = 0; br = 0; req = 0; rdy = 0;
  endtask

  initial begin
    logic [5:0] e0, e1;
    model_reset(0); model_reset(1);
    #2;
    model_eval(0, e0); check_inst(0, e0);
    model_eval(1, e1); check_inst(1, e1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Load-use: lw x5 followed by a use of x5
    mr = 1; exrd = 5; rs1 = 5; u1 = 1;
    run_cycle();
    check_eq("lu_cnt", 32'(bus_a.o_stall_cnt), 32'd1);
    clear_inputs(); run_cycle();

    // No false hazards
    mr = 1; exrd = 0; rs1 = 0; u1 = 1; run_cycle();
    clear_inputs(); mr = 1; exrd = 5; rs2 = 5; u2 = 0; run_cycle();
    clear_inputs();

    // Taken branch
    br = 1; run_cycle();
    check_eq("br_state", 32'(bus_a.o_state), 32'd2);
    br = 0; run_cycle(); run_cycle();

    // Memory wait: four not-ready cycles then ready
    req = 1; rdy = 0;
    repeat (4) run_cycle();
    rdy = 1; run_cycle();
    check_eq("mw_cnt", 32'(bus_a.o_stall_cnt), 32'd5);
    check_eq("sat_cnt", 32'(bus_b.o_stall_cnt), 32'd3);
    clear_inputs(); run_cycle();

    // Branch wins over load-use
    br = 1; mr = 1; exrd = 7; rs1 = 7; u1 = 1; run_cycle();
    clear_inputs(); run_cycle(); run_cycle();

    // Timeout on the short-timeout instance
    req = 1; rdy = 0;
    repeat (4) run_cycle();
    check_eq("to_err", 32'(bus_b.o_mem_err), 32'd1);
    req = 0; run_cycle(); run_cycle();

    // Reset in the middle of a memory wait
    req = 1; rdy = 0;
    repeat (2) run_cycle();
    mid_reset();
    clear_inputs(); run_cycle();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rs1  = 5'($urandom_range(0, 3));
      rs2  = 5'($urandom_range(0, 3));
      exrd = 5'($urandom_range(0, 3));
      u1   = 1'($urandom_range(0, 1));
      u2   = 1'($urandom_range(0, 1));
      mr   = ($urandom_range(0, 2) == 0);
      br   = ($urandom_range(0, 7) == 0);
      req  = ($urandom_range(0, 3) == 0);
      rdy  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 149) == 0) mid_reset();
      else run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
